// File: rtl/plot_framebuffer_scanout.sv
// Pixel-write framebuffer (FB_W x FB_H x 3 bits) with VGA scanout. Each stored pixel is
// replicated 2**SCALE_LOG2 times horizontally and vertically.
module plot_framebuffer_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK,
  output logic       VGA_SYNC,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCW      = $clog2(H_TOTAL);
  localparam int unsigned VCW      = $clog2(V_TOTAL);
  localparam int unsigned FB_CELLS = FB_W * FB_H;
  localparam int unsigned AW       = $clog2(FB_CELLS);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_FIRST = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_LAST  = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_FIRST = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_LAST  = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic           pix_en_q;
  logic           vga_clk_q;
  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;

  // Counter-stage decode
  logic          active0, hs0, vs0;
  logic [AW-1:0] rd_addr;
  // Pipe stage 1 (RAM read) and stage 2 (output register)
  logic          hs1_q, vs1_q, blank1_q;
  logic          hs2_q, vs2_q, blank2_q;
  logic [2:0]    rd_data_q;
  logic [2:0]    rgb_q;

  // Write port
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    mem [FB_CELLS];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      pix_en_q  <= ~pix_en_q;
      vga_clk_q <= pix_en_q;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    active0 = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs0     = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs0     = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    rd_addr = AW'(v_cnt_q >> SCALE_LOG2) * AW'(FB_W) + AW'(h_cnt_q >> SCALE_LOG2);
  end

  always_comb begin
    wr_en   = plot && (32'(x) < FB_W) && (32'(y) < FB_H);
    wr_addr = AW'(y) * AW'(FB_W) + AW'(x);
  end

  // Framebuffer contents deliberately survive reset. Same-cell read/write in one
  // cycle returns the old value.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= colour;
    end
    if (pix_en_q && active0) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      blank1_q <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
      rgb_q    <= 3'b000;
    end else if (pix_en_q) begin
      hs1_q    <= hs0;
      vs1_q    <= vs0;
      blank1_q <= active0;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      blank2_q <= blank1_q;
      rgb_q    <= blank1_q ? rd_data_q : 3'b000;
    end
  end

  always_comb begin
    VGA_R       = {8{rgb_q[2]}};
    VGA_G       = {8{rgb_q[1]}};
    VGA_B       = {8{rgb_q[0]}};
    VGA_HS      = hs2_q;
    VGA_VS      = vs2_q;
    VGA_BLANK   = blank2_q;
    VGA_SYNC    = 1'b0;
    VGA_CLK     = vga_clk_q;
    frame_start = pix_en_q && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: tb/tb_plot_framebuffer_scanout.sv
// Randomised bench for plot_framebuffer_scanout on a shrunken raster, checked against a
// pixel-level model of the framebuffer and VGA timing rules.
module tb_plot_framebuffer_scanout;

  localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
  localparam int FBW = 8, FBH = 6;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME_CLKS = 2 * HT * VT;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK, frame_start;
  logic [26:0] obs;

  int tests = 0;
  int fails = 0;
  int cur_k = 0;
  logic [2:0] model_mem [FBW*FBH];

  plot_framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .FB_W(FBW), .FB_H(FBH), .SCALE_LOG2(2)
  ) dut (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  assign obs = {VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B};

  // Expected {HS, VS, BLANK, R, G, B} for raster position (h, v).
  function automatic logic [26:0] expect_px(int h, int v);
    logic [2:0] c;
    logic bl, hs, vs;
    bl = (h < HA) && (v < VA);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
    c = 3'b000;
    if (bl) c = model_mem[(v / 4) * FBW + (h / 4)];
    return {hs, vs, bl, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  task automatic write_cell(input int cx, input int cy, input logic [2:0] c);
    @(negedge clock);
    x = 8'(cx);
    y = 7'(cy);
    colour = c;
    plot = 1'b1;
    @(negedge clock);
    plot = 1'b0;
    if (cx < FBW && cy < FBH) model_mem[cy * FBW + cx] = c;
  endtask

  // Leaves the bench at the negedge where raster pixel 0 is on the outputs.
  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < 2 * FRAME_CLKS + 10);
    if (!frame_start) begin
      tests++;
      fails++;
      $display("FAIL sync_frame: frame_start not seen within %0d clocks", n);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    cur_k = 0;
  endtask

  task automatic advance_to(input int k);
    repeat (2 * (k - cur_k)) @(negedge clock);
    cur_k = k;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (4) @(negedge clock);
    tests++;
    if ({VGA_HS, VGA_VS, VGA_BLANK, VGA_CLK, frame_start, VGA_SYNC} !== 6'b110000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 110000",
               {VGA_HS, VGA_VS, VGA_BLANK, VGA_CLK, frame_start, VGA_SYNC});
    end
    tests++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      fails++;
      $display("FAIL reset_rgb: got %h want 000000", {VGA_R, VGA_G, VGA_B});
    end
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      tests++;
      if (VGA_CLK !== 1'(i % 2)) begin
        fails++;
        $display("FAIL vga_clk[%0d]: got %b want %0d", i, VGA_CLK, i % 2);
      end
      if (i == 0) begin
        tests++;
        if (frame_start !== 1'b1) begin
          fails++;
          $display("FAIL first_frame_start: got %b want 1", frame_start);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    logic [26:0] exp;
    for (int i = 0; i < FBW * FBH; i++) write_cell(i % FBW, i / FBW, 3'($urandom_range(0, 7)));
    sync_frame();
    for (int k = 0; k < HT * VT; k++) begin
      advance_to(k);
      exp = expect_px(k % HT, k / HT);
      tests++;
      if ({obs, VGA_CLK} !== {exp, 1'b1}) begin
        fails++;
        $display("FAIL frame px h=%0d v=%0d: got %h clk=%b want %h clk=1",
                 k % HT, k / HT, obs, VGA_CLK, exp);
      end
    end
  endtask

  task automatic test_frame_period();
    int n, hs_n, vs_n, bl_n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_start && n < FRAME_CLKS + 10);
    n = 0; hs_n = 0; vs_n = 0; bl_n = 0;
    do begin
      @(negedge clock);
      n++;
      if (!VGA_HS) hs_n++;
      if (!VGA_VS) vs_n++;
      if (VGA_BLANK) bl_n++;
    end while (!frame_start && n < 2 * FRAME_CLKS);
    tests++;
    if (n !== FRAME_CLKS) begin
      fails++;
      $display("FAIL frame_period: got %0d want %0d", n, FRAME_CLKS);
    end
    tests++;
    if ({hs_n, vs_n, bl_n} !== {2 * HSY * VT, 2 * VSY * HT, 2 * HA * VA}) begin
      fails++;
      $display("FAIL sync_counts: got hs=%0d vs=%0d blank=%0d want %0d %0d %0d",
               hs_n, vs_n, bl_n, 2 * HSY * VT, 2 * VSY * HT, 2 * HA * VA);
    end
  endtask

  task automatic test_top_left();
    logic [23:0] want;
    write_cell(0, 0, 3'b100);
    sync_frame();
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 5; h++) begin
        advance_to(v * HT + h);
        want = (h < 4) ? 24'hFF0000 : expect_px(h, v)[23:0];
        tests++;
        if (obs[23:0] !== want) begin
          fails++;
          $display("FAIL top_left h=%0d v=%0d: got %h want %h", h, v, obs[23:0], want);
        end
      end
    end
  endtask

  task automatic test_bottom_right();
    logic [24:0] want;
    write_cell(FBW - 1, FBH - 1, 3'b111);
    sync_frame();
    for (int v = VA - 4; v < VA; v++) begin
      for (int h = HA - 4; h <= HA; h++) begin
        advance_to(v * HT + h);
        want = (h < HA) ? 25'h1FFFFFF : 25'h0;
        tests++;
        if (obs[24:0] !== want) begin
          fails++;
          $display("FAIL bottom_right h=%0d v=%0d: got %h want %h", h, v, obs[24:0], want);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    write_cell(0, 0, 3'b101);
    write_cell(0, 1, 3'b011);
    write_cell(FBW, 0, 3'b010);
    write_cell(0, FBH, 3'b010);
    write_cell(255, 127, 3'b010);
    sync_frame();
    tests++;
    if (obs[23:0] !== 24'hFF00FF) begin
      fails++;
      $display("FAIL oor_cell00: got %h want ff00ff", obs[23:0]);
    end
    advance_to(4 * HT);
    tests++;
    if (obs[23:0] !== 24'h00FFFF) begin
      fails++;
      $display("FAIL oor_cell01: got %h want 00ffff", obs[23:0]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] want;
    write_cell(2, 2, 3'b001);
    sync_frame();
    advance_to(15 * HT + 5);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    tests++;
    if ({obs, VGA_CLK, frame_start} !== {3'b110, 24'h0, 2'b00}) begin
      fails++;
      $display("FAIL midreset_state: got %h clk=%b fs=%b want 6000000 0 0",
               obs, VGA_CLK, frame_start);
    end
    resetn = 1'b1;
    @(negedge clock);
    tests++;
    if (frame_start !== 1'b1) begin
      fails++;
      $display("FAIL midreset_restart: got %b want 1", frame_start);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    cur_k = 0;
    for (int v = 8; v < 12; v++) begin
      for (int h = 8; h <= 12; h++) begin
        advance_to(v * HT + h);
        want = (h < 12) ? 24'h0000FF : expect_px(h, v)[23:0];
        tests++;
        if ({obs[26:24], obs[23:0]} !== {3'b111, want}) begin
          fails++;
          $display("FAIL midreset_px h=%0d v=%0d: got %h want %h", h, v, obs, {3'b111, want});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_frame_period();
    test_top_left();
    test_bottom_right();
    test_out_of_range();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
